// File: rtl/vga_fb_writer_if.sv
// ============================================================================
//  Module      : vga_fb_writer_if
//  Description : iomem bus, framebuffer write port and vsync/irq bundle.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface vga_fb_writer_if #(
    parameter int FB_AW = 15
);
    logic              iomem_valid;
    logic              iomem_ready;
    logic [3:0]        iomem_wstrb;
    logic [31:0]       iomem_addr;
    logic [31:0]       iomem_wdata;
    logic [31:0]       iomem_rdata;

    logic              fb_valid;
    logic              fb_ready;
    logic [FB_AW-1:0]  fb_addr;
    logic [31:0]       fb_data;
    logic [3:0]        fb_mask;

    logic              vsync_pulse;
    logic              irq;

    // slave: the writer block; master: the SoC/VGA environment around it
    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata,
        output fb_valid, fb_addr, fb_data, fb_mask,
        input  fb_ready,
        input  vsync_pulse,
        output irq
    );

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata,
        input  fb_valid, fb_addr, fb_data, fb_mask,
        output fb_ready,
        output vsync_pulse,
        input  irq
    );
endinterface

`default_nettype wire

// File: rtl/vga_fb_writer.sv
// ============================================================================
//  Module      : vga_fb_writer
//  Description : iomem slave buffering CPU framebuffer writes in a FIFO toward
//                the VGA core, with auto-increment cursor and vsync interrupt.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_fb_writer #(
    parameter logic [7:0] ADDR_HI    = 8'h04,
    parameter int         FIFO_DEPTH = 16,
    parameter int         FB_AW      = 15
) (
    input  logic           clk,
    input  logic           reset,
    vga_fb_writer_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = FB_AW + 32 + 4;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_CURSOR = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    logic [2:0]        ctrl_q,    ctrl_d;
    logic [FB_AW-1:0]  cursor_q,  cursor_d;
    logic              flag_q,    flag_d;
    logic              ready_q,   ready_d;
    logic [31:0]       rdata_q,   rdata_d;
    logic [LVL_W-1:0]  wr_ptr_q,  rd_ptr_q;
    logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];

    logic              accept;
    logic              is_write;
    logic [1:0]        reg_sel;
    logic              data_wr;
    logic              push;
    logic              pop;
    logic [LVL_W-1:0]  level;
    logic              empty;
    logic              full;
    logic              fb_valid;
    logic [ENT_W-1:0]  head;
    logic [31:0]       byte_mask;
    logic [31:0]       reg_rdata;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{bus.iomem_addr[23:4], bus.iomem_addr[1:0]};

    // Blocking on ready_q makes every access a single acknowledged transfer.
    assign accept   = bus.iomem_valid && !ready_q && (bus.iomem_addr[31:24] == ADDR_HI);
    assign is_write = |bus.iomem_wstrb;
    assign reg_sel  = bus.iomem_addr[3:2];
    assign data_wr  = accept && is_write && (reg_sel == REG_DATA);

    assign level    = wr_ptr_q - rd_ptr_q;
    assign empty    = (level == '0);
    assign full     = (level == LVL_FULL);

    // A full FIFO stalls the write; it retries each cycle until a pop frees space.
    assign push     = data_wr && !full;
    assign fb_valid = ctrl_q[0] && !empty;
    assign pop      = fb_valid && bus.fb_ready;

    assign head     = mem_q[rd_ptr_q[PTR_W-1:0]];

    assign byte_mask = {{8{bus.iomem_wstrb[3]}}, {8{bus.iomem_wstrb[2]}},
                        {8{bus.iomem_wstrb[1]}}, {8{bus.iomem_wstrb[0]}}};

    always_comb begin
        reg_rdata = '0;
        case (reg_sel)
            REG_CTRL:   reg_rdata = {29'd0, ctrl_q};
            REG_CURSOR: reg_rdata = {{(32-FB_AW){1'b0}}, cursor_q};
            REG_DATA:   reg_rdata = '0;
            REG_STATUS: reg_rdata = {21'd0, flag_q, empty, full, 8'(level)};
            default:    reg_rdata = '0;
        endcase
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        cursor_d = cursor_q;
        flag_d   = flag_q;
        ready_d  = accept && !(data_wr && full);
        rdata_d  = '0;

        if (ready_d && !is_write) begin
            rdata_d = reg_rdata;
        end

        if (accept && is_write && (reg_sel == REG_CTRL) && bus.iomem_wstrb[0]) begin
            ctrl_d = bus.iomem_wdata[2:0];
        end

        if (accept && is_write && (reg_sel == REG_CURSOR)) begin
            cursor_d = (cursor_q & ~byte_mask[FB_AW-1:0])
                     | (bus.iomem_wdata[FB_AW-1:0] & byte_mask[FB_AW-1:0]);
        end else if (push && ctrl_q[1]) begin
            cursor_d = cursor_q + FB_AW'(1);
        end

        // A vsync pulse beats a clear arriving in the same cycle.
        if (bus.vsync_pulse) begin
            flag_d = 1'b1;
        end else if (accept && is_write && (reg_sel == REG_STATUS) && bus.iomem_wdata[10]) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q   <= '0;
            cursor_q <= '0;
            flag_q   <= 1'b0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            cursor_q <= cursor_d;
            flag_q   <= flag_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + LVL_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= {cursor_q, bus.iomem_wdata, bus.iomem_wstrb};
        end
    end

    assign bus.iomem_ready = ready_q;
    assign bus.iomem_rdata = rdata_q;
    assign bus.fb_valid    = fb_valid;
    assign bus.fb_addr     = head[ENT_W-1:36];
    assign bus.fb_data     = head[35:4];
    assign bus.fb_mask     = head[3:0];
    assign bus.irq         = flag_q && ctrl_q[2];

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_writer.sv
// ============================================================================
//  Module      : tb_vga_fb_writer
//  Description : Scoreboard bench for vga_fb_writer bus and framebuffer ports.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_fb_writer;
    localparam int          FB_AW  = 15;
    localparam logic [31:0] A_CTRL = 32'h0400_0000;
    localparam logic [31:0] A_CUR  = 32'h0400_0004;
    localparam logic [31:0] A_DATA = 32'h0400_0008;
    localparam logic [31:0] A_STAT = 32'h0400_000C;

    typedef struct packed {
        logic        rd;
        logic [31:0] data;
    } bus_exp_t;

    typedef struct packed {
        logic [FB_AW-1:0] addr;
        logic [31:0]      data;
        logic [3:0]       mask;
    } fb_exp_t;

    logic clk = 1'b0;
    logic reset;

    vga_fb_writer_if #(.FB_AW(FB_AW)) bus ();

    vga_fb_writer #(
        .ADDR_HI   (8'h04),
        .FIFO_DEPTH(16),
        .FB_AW     (FB_AW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    bus_exp_t bus_q[$];
    fb_exp_t  fb_q[$];
    int       errors = 0;
    int       checks = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected by scoreboard", name);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (bus.iomem_ready) begin
                if (bus_q.size() == 0) begin
                    fail("unexpected_iomem_ready");
                end else begin
                    bus_exp_t e;
                    e = bus_q.pop_front();
                    if (e.rd) chk("iomem_rdata", bus.iomem_rdata, e.data);
                end
            end
            if (bus.fb_valid && bus.fb_ready) begin
                if (fb_q.size() == 0) begin
                    fail("unexpected_fb_write");
                end else begin
                    fb_exp_t f;
                    f = fb_q.pop_front();
                    chk("fb_addr", bus.fb_addr, f.addr);
                    chk("fb_data", bus.fb_data, f.data);
                    chk("fb_mask", bus.fb_mask, f.mask);
                end
            end
        end
    endtask

    task automatic bus_acc(input logic [31:0] addr, input logic [3:0] strb,
                           input logic [31:0] wdata, input logic [31:0] exp, output int lat);
        int n;
        bus_q.push_back('{rd: (strb == 4'h0), data: exp});
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = addr;
        bus.iomem_wstrb = strb;
        bus.iomem_wdata = wdata;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.iomem_ready && n < 60);
        if (!bus.iomem_ready) fail("bus_timeout");
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        lat = n;
    endtask

    task automatic drive_raw(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wdata);
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = addr;
        bus.iomem_wstrb = strb;
        bus.iomem_wdata = wdata;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int r;
        reset           = 1'b1;
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        bus.iomem_addr  = '0;
        bus.iomem_wdata = '0;
        bus.fb_ready    = 1'b0;
        bus.vsync_pulse = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        chk("reset_fb_valid", bus.fb_valid, 0);
        chk("reset_irq", bus.irq, 0);
        chk("reset_ready", bus.iomem_ready, 0);
        bus_acc(A_STAT, 4'h0, 0, 32'h200, lat);
        chk("read_latency", lat, 1);
        bus_acc(A_CTRL, 4'h0, 0, 32'h0, lat);

        // Auto-increment with cursor wrap, draining freely
        bus.fb_ready = 1'b1;
        bus_acc(A_CTRL, 4'h1, 32'h3, 0, lat);
        bus_acc(A_CUR, 4'hF, 32'h7FFE, 0, lat);
        fb_q.push_back('{addr: 15'h7FFE, data: 32'hA, mask: 4'hF});
        fb_q.push_back('{addr: 15'h7FFF, data: 32'hB, mask: 4'hF});
        fb_q.push_back('{addr: 15'h0000, data: 32'hC, mask: 4'hF});
        bus_acc(A_DATA, 4'hF, 32'hA, 0, lat);
        bus_acc(A_DATA, 4'hF, 32'hB, 0, lat);
        bus_acc(A_DATA, 4'hF, 32'hC, 0, lat);
        bus_acc(A_CUR, 4'h0, 0, 32'h1, lat);
        repeat (3) tick();
        chk("drain1_empty", fb_q.size(), 0);

        // Fill 16 with drain off, then a 17th write stalls
        bus.fb_ready = 1'b0;
        bus_acc(A_CTRL, 4'h1, 32'h2, 0, lat);
        for (int i = 0; i < 16; i++) begin
            fb_q.push_back('{addr: 15'(1 + i), data: 32'h100 + 32'(i), mask: 4'hF});
            bus_acc(A_DATA, 4'hF, 32'h100 + 32'(i), 0, lat);
        end
        bus_acc(A_STAT, 4'h0, 0, 32'h110, lat);
        fb_q.push_back('{addr: 15'd17, data: 32'h110, mask: 4'hF});
        drive_raw(A_DATA, 4'hF, 32'h110);
        r = 0;
        repeat (5) begin
            tick();
            if (bus.iomem_ready) r++;
        end
        chk("stall_no_ready", r, 0);
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        bus_acc(A_CTRL, 4'h1, 32'h3, 0, lat);
        bus_q.push_back('{rd: 1'b0, data: 32'h0});
        drive_raw(A_DATA, 4'hF, 32'h110);
        tick();
        chk("stall_ready_low", bus.iomem_ready, 0);
        bus.fb_ready = 1'b1;
        tick();
        chk("ready_at_pop_edge", bus.iomem_ready, 0);
        tick();
        chk("ready_after_pop", bus.iomem_ready, 1);
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        repeat (20) tick();
        chk("drain2_empty", fb_q.size(), 0);
        bus_acc(A_STAT, 4'h0, 0, 32'h200, lat);

        // Partial mask and backpressure hold
        bus.fb_ready = 1'b0;
        fb_q.push_back('{addr: 15'd18, data: 32'hDEADBEEF, mask: 4'h3});
        bus_acc(A_DATA, 4'h3, 32'hDEADBEEF, 0, lat);
        chk("push_to_valid", bus.fb_valid, 1);
        repeat (5) begin
            tick();
            chk("hold_valid", bus.fb_valid, 1);
            chk("hold_addr", bus.fb_addr, 18);
            chk("hold_data", bus.fb_data, 32'hDEADBEEF);
            chk("hold_mask", bus.fb_mask, 4'h3);
        end
        bus.fb_ready = 1'b1;
        tick();
        chk("valid_after_pop", bus.fb_valid, 0);

        // Vsync flag, irq gating, set-wins-over-clear
        bus.vsync_pulse = 1'b1;
        tick();
        bus.vsync_pulse = 1'b0;
        chk("irq_gated_off", bus.irq, 0);
        bus_acc(A_STAT, 4'h0, 0, 32'h600, lat);
        bus_acc(A_CTRL, 4'h1, 32'h7, 0, lat);
        chk("irq_after_ctrl", bus.irq, 1);
        bus_acc(A_STAT, 4'hF, 32'h400, 0, lat);
        chk("irq_cleared", bus.irq, 0);
        bus.vsync_pulse = 1'b1;
        tick();
        bus.vsync_pulse = 1'b0;
        chk("irq_on_vsync", bus.irq, 1);
        bus_q.push_back('{rd: 1'b0, data: 32'h0});
        drive_raw(A_STAT, 4'hF, 32'h400);
        bus.vsync_pulse = 1'b1;
        tick();
        bus.vsync_pulse = 1'b0;
        chk("clear_ready", bus.iomem_ready, 1);
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        chk("irq_set_wins", bus.irq, 1);
        bus_acc(A_STAT, 4'h0, 0, 32'h600, lat);
        bus_acc(A_STAT, 4'hF, 32'h400, 0, lat);
        chk("irq_quiet_clear", bus.irq, 0);
        bus_acc(A_STAT, 4'h0, 0, 32'h200, lat);

        // Reset during a stalled write with 16 entries queued
        bus.fb_ready = 1'b0;
        bus_acc(A_CTRL, 4'h1, 32'h3, 0, lat);
        for (int i = 0; i < 16; i++) begin
            bus_acc(A_DATA, 4'hF, 32'h200 + 32'(i), 0, lat);
        end
        chk("pre_reset_valid", bus.fb_valid, 1);
        drive_raw(A_DATA, 4'hF, 32'h3FF);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("reset_abort_ready", bus.iomem_ready, 0);
        chk("reset_flush_valid", bus.fb_valid, 0);
        reset = 1'b0;
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        tick();
        chk("post_reset_ready", bus.iomem_ready, 0);
        bus_acc(A_STAT, 4'h0, 0, 32'h200, lat);
        bus_acc(A_CTRL, 4'h0, 0, 32'h0, lat);

        repeat (3) tick();
        chk("bus_scoreboard_empty", bus_q.size(), 0);
        chk("fb_scoreboard_empty", fb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_fb_writer.md
# vga_fb_writer

Memory-mapped iomem slave that takes framebuffer writes from the PicoSoC CPU and delivers them to the VGA core's framebuffer write port. Writes are buffered in a FIFO so the CPU does not wait on the VGA core. The block also provides an auto-incrementing cursor and a sticky vsync flag with an interrupt. It sits between the SoC iomem bus (decode `iomem_addr[31:24] == ADDR_HI`) and the `vga` block, on the CPU clock domain.

## Interface
- `ADDR_HI`, 8'h04, iomem page decoded by this slave.
- `FIFO_DEPTH`, 16, FIFO entries; must be a power of 2, at least 2.
- `FB_AW`, 15, framebuffer word-address width.

Ports:
- `clk` in 1: CPU clock (clk2 domain).
- `reset` in 1: synchronous, active-high.
- `iomem_valid` in 1: bus request.
- `iomem_ready` out 1: one-cycle acknowledge.
- `iomem_wstrb` in 4: byte strobes; 0 means read.
- `iomem_addr` in 32: bus address; [31:24] decode, [3:2] register select.
- `iomem_wdata` in 32: write data.
- `iomem_rdata` out 32: read data, valid while `iomem_ready` = 1.
- `fb_valid` out 1: framebuffer write request.
- `fb_ready` in 1: VGA core accepts the write.
- `fb_addr` out FB_AW: framebuffer word address.
- `fb_data` out 32: write data.
- `fb_mask` out 4: byte enables.
- `vsync_pulse` in 1: one-cycle pulse per frame, already synchronised to `clk`.
- `irq` out 1: level interrupt.

## Operation
- Register map (`iomem_addr[3:2]`):
  - 0 CTRL (R/W, byte 0 only): bit0 DRAIN_EN, bit1 AUTO_INC, bit2 IRQ_EN.
  - 1 CURSOR (R/W, per-byte strobes, bits [FB_AW-1:0]; upper bits read 0).
  - 2 DATA (write only; reads return 0).
  - 3 STATUS (read): [7:0] fill level, bit8 FULL, bit9 EMPTY, bit10 VSYNC_FLAG. Writing bit10 = 1 clears the flag; all other STATUS writes are ignored.
- A bus access is accepted when `iomem_valid && !iomem_ready` and the page matches.
  - Non-DATA access: `iomem_ready` pulses on the next edge.
  - DATA write with any strobe set: pushes {CURSOR, wdata, wstrb}. If AUTO_INC = 1, CURSOR increments by 1 and wraps modulo 2^FB_AW.
  - DATA write while FULL: stalls. `iomem_ready` stays low until space frees, then the push happens and `iomem_ready` pulses.
- Drain:
  - `fb_valid` = DRAIN_EN && !EMPTY.
  - `fb_addr`, `fb_data`, `fb_mask` carry the FIFO head.
  - An entry is popped on `fb_valid && fb_ready`.
  - Clearing DRAIN_EN holds the FIFO contents. An in-flight handshake on that same cycle still completes.
- Simultaneous push and pop: level is unchanged. A push into an EMPTY FIFO is visible at the head on the next cycle.
- VSYNC_FLAG:
  - Set by `vsync_pulse`.
  - Set wins over a same-cycle clear.
  - `irq` = VSYNC_FLAG && IRQ_EN.
- The slave never drives `iomem_ready` for other pages.

## Timing
- Reset: `iomem_ready` = 0, `iomem_rdata` = 0, CTRL = 0, CURSOR = 0, FIFO empty (level 0), VSYNC_FLAG = 0, `fb_valid` = 0, `irq` = 0. A reset in mid-operation discards FIFO contents and aborts any stalled DATA write; no ready pulse follows.
- Register read/write latency: `iomem_ready` asserts 1 cycle after the first valid cycle and lasts exactly 1 cycle.
- Push to `fb_valid`: push edge N gives `fb_valid` = 1 in cycle N+1 (given DRAIN_EN and a previously empty FIFO).
- Drain throughput: 1 entry per cycle while `fb_ready` = 1.
- Full-FIFO stall: `iomem_ready` pulses 1 cycle after the first pop edge.
- STATUS reflects the state registered before the access edge.
- `irq` changes 1 cycle after `vsync_pulse`, or 1 cycle after a CTRL/STATUS write.
- Fill level width is clog2(FIFO_DEPTH)+1 and saturates only structurally (it cannot exceed FIFO_DEPTH).

## Test plan
- Reset, then read STATUS → 0x200 (EMPTY). Read CTRL → 0. `fb_valid` = 0, `irq` = 0.
- CTRL = 0x3, CURSOR = 0x7FFE, three DATA writes (0xA, 0xB, 0xC) with `fb_ready` = 1 → `fb` sequence (0x7FFE, 0xA), (0x7FFF, 0xB), (0x0000, 0xC), masks 0xF. CURSOR reads 0x0001.
- DRAIN_EN = 0, 17 DATA writes → the 17th stalls with `iomem_ready` low. STATUS (read before the 17th write) = 0x110. Set DRAIN_EN with `fb_ready` = 1 → the stalled write completes 1 cycle after the first pop. All 17 data words appear in order.
- DATA write with wstrb = 0x3 → `fb_mask` = 0x3. Hold `fb_ready` = 0 for 5 cycles → `fb_valid` and the head stay stable until the handshake.
- IRQ_EN = 1, `vsync_pulse` → `irq` = 1 the next cycle. STATUS write 0x400 on the same cycle as a new `vsync_pulse` → flag stays 1. Clear on a quiet cycle → `irq` = 0.
- Assert `reset` while a DATA write is stalled with 16 entries queued → no `iomem_ready`, level 0, `fb_valid` = 0 the next cycle.
